ddr3_cmd_decoder: RTL and testbench



---
 rtl/ddr3_pkg.sv | 25 ++
 rtl/ddr3_burst_window.sv | 26 ++
 rtl/ddr3_cmd_decoder.sv | 158 +++++++++++++++
 tb/tb_ddr3_cmd_decoder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr3_pkg.sv
// Shared types for the DDR3 command-bus decoder.
// Command and error encodings plus burst length.
package ddr3_pkg;

  typedef enum logic [2:0] {
    C_MRS = 3'd0,
    C_REF = 3'd1,
    C_PRE = 3'd2,
    C_ACT = 3'd3,
    C_WR  = 3'd4,
    C_RD  = 3'd5,
    C_ZQC = 3'd6,
    C_NOP = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    E_NONE      = 2'd0,
    E_ACT_OPEN  = 2'd1,
    E_RW_CLOSED = 2'd2,
    E_REF_OPEN  = 2'd3
  } err_e;

  localparam int BL_CYCLES = 4;

endpackage

// File: rtl/ddr3_burst_window.sv
// Delayed data-burst window generator.
// A start pulse opens the window LAT+1 cycles later for BL_CYCLES cycles.
module ddr3_burst_window
  import ddr3_pkg::*;
#(
  parameter int LAT = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic window
);

  localparam int DEPTH = LAT + BL_CYCLES;

  logic [DEPTH-1:0] pipe;

  // Shift burst starts down the latency line; reset clears it at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pipe <= '0;
    else        pipe <= {pipe[DEPTH-2:0], start};
  end

  assign window = |pipe[DEPTH-1:LAT];

endmodule

// File: rtl/ddr3_cmd_decoder.sv
// DDR3 command-bus decoder: bank tracking, burst windows,
// protocol error flags and saturating RD/WR counters.
module ddr3_cmd_decoder
  import ddr3_pkg::*;
#(
  parameter int BANK_WIDTH = 3,
  parameter int ROW_WIDTH  = 15,
  parameter int COL_WIDTH  = 10,
  parameter int CL         = 6,
  parameter int CWL        = 5,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     cke,
  input  logic                     cs_n,
  input  logic                     ras_n,
  input  logic                     cas_n,
  input  logic                     we_n,
  input  logic [BANK_WIDTH-1:0]    ba,
  input  logic [ROW_WIDTH-1:0]     addr,
  output logic                     cmd_valid,
  output logic [2:0]               cmd_code,
  output logic [BANK_WIDTH-1:0]    cmd_bank,
  output logic [ROW_WIDTH-1:0]     cmd_row,
  output logic [COL_WIDTH-1:0]     cmd_col,
  output logic [2**BANK_WIDTH-1:0] bank_open,
  output logic                     rd_window,
  output logic                     wr_window,
  output logic                     err_valid,
  output logic [1:0]               err_code,
  output logic [CNT_WIDTH-1:0]     rd_count,
  output logic [CNT_WIDTH-1:0]     wr_count
);

  localparam int NB = 2**BANK_WIDTH;
  // A10 is the auto-precharge flag, never a column bit.
  localparam logic [COL_WIDTH-1:0] COL_MASK = ~COL_WIDTH'(1 << 10);

  cmd_e                 code;
  logic                 live;
  logic                 hit;
  logic                 a10;
  logic                 rw;
  logic [COL_WIDTH-1:0] col;
  logic [NB-1:0]        open_n;
  logic                 is_err;
  err_e                 err_n;
  logic                 rd_go;
  logic                 wr_go;
  logic                 row_we;

  logic [ROW_WIDTH-1:0] row_tbl [NB];
  logic                 unused_row_parity;

  assign code = cmd_e'({ras_n, cas_n, we_n});
  assign live = cke && !cs_n && (code != C_NOP);
  assign hit  = bank_open[ba];
  assign a10  = addr[10];
  assign rw   = (code == C_RD) || (code == C_WR);
  assign col  = addr[COL_WIDTH-1:0] & COL_MASK;

  // Decode the sampled command into bank-state and burst actions.
  always_comb begin
    open_n = bank_open;
    is_err = 1'b0;
    err_n  = E_NONE;
    rd_go  = 1'b0;
    wr_go  = 1'b0;
    row_we = 1'b0;
    if (live) begin
      unique case (code)
        C_ACT: begin
          if (hit) begin
            is_err = 1'b1;
            err_n  = E_ACT_OPEN;
          end
          open_n[ba] = 1'b1;
          row_we     = 1'b1;
        end
        C_PRE: begin
          if (a10) open_n     = '0;
          else     open_n[ba] = 1'b0;
        end
        C_RD, C_WR: begin
          if (hit) begin
            rd_go = (code == C_RD);
            wr_go = (code == C_WR);
            if (a10) open_n[ba] = 1'b0;
          end else begin
            is_err = 1'b1;
            err_n  = E_RW_CLOSED;
          end
        end
        C_REF: begin
          if (|bank_open) begin
            is_err = 1'b1;
            err_n  = E_REF_OPEN;
          end
        end
        default: ;
      endcase
    end
  end

  // Register decoded command, bank state, errors and counters.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cmd_valid <= 1'b0;
      cmd_code  <= '0;
      cmd_bank  <= '0;
      cmd_row   <= '0;
      cmd_col   <= '0;
      bank_open <= '0;
      err_valid <= 1'b0;
      err_code  <= '0;
      rd_count  <= '0;
      wr_count  <= '0;
      for (int i = 0; i < NB; i++) row_tbl[i] <= '0;
    end else begin
      cmd_valid <= live;
      cmd_code  <= live ? code : 3'd0;
      cmd_bank  <= live ? ba : '0;
      cmd_row   <= (live && code == C_ACT) ? addr : '0;
      cmd_col   <= (live && rw) ? col : '0;
      bank_open <= open_n;
      err_valid <= is_err;
      if (is_err) err_code <= err_n;
      if (row_we) row_tbl[ba] <= addr;
      if (rd_go && rd_count != '1)
        rd_count <= rd_count + CNT_WIDTH'(1);
      if (wr_go && wr_count != '1)
        wr_count <= wr_count + CNT_WIDTH'(1);
    end
  end

  // The open-row table is bookkeeping with no consumer on this block yet.
  always_comb begin
    unused_row_parity = 1'b0;
    for (int i = 0; i < NB; i++)
      unused_row_parity = unused_row_parity ^ (^row_tbl[i]);
  end

  ddr3_burst_window #(.LAT(CL)) u_rd_win (
    .clk    (CLK),
    .rst_n  (RSTn),
    .start  (rd_go),
    .window (rd_window)
  );

  ddr3_burst_window #(.LAT(CWL)) u_wr_win (
    .clk    (CLK),
    .rst_n  (RSTn),
    .start  (wr_go),
    .window (wr_window)
  );

endmodule

// File: tb/tb_ddr3_cmd_decoder.sv
// Scoreboard bench for ddr3_cmd_decoder.
// Driver pushes expected responses; a negedge monitor pops and compares.
module tb_ddr3_cmd_decoder;

  localparam int CL  = 6;
  localparam int CWL = 5;

  localparam logic [3:0] B_MRS = 4'b0000;
  localparam logic [3:0] B_REF = 4'b0001;
  localparam logic [3:0] B_PRE = 4'b0010;
  localparam logic [3:0] B_ACT = 4'b0011;
  localparam logic [3:0] B_WR  = 4'b0100;
  localparam logic [3:0] B_RD  = 4'b0101;
  localparam logic [3:0] B_ZQC = 4'b0110;
  localparam logic [3:0] B_NOP = 4'b0111;
  localparam logic [3:0] B_DES = 4'b1000;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        cke = 1'b1;
  logic        cs_n = 1'b0;
  logic        ras_n = 1'b1;
  logic        cas_n = 1'b1;
  logic        we_n = 1'b1;
  logic [2:0]  ba = '0;
  logic [14:0] addr = '0;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [2:0]  cmd_bank;
  logic [14:0] cmd_row;
  logic [9:0]  cmd_col;
  logic [7:0]  bank_open;
  logic        rd_window;
  logic        wr_window;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  ddr3_cmd_decoder dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .cke       (cke),
    .cs_n      (cs_n),
    .ras_n     (ras_n),
    .cas_n     (cas_n),
    .we_n      (we_n),
    .ba        (ba),
    .addr      (addr),
    .cmd_valid (cmd_valid),
    .cmd_code  (cmd_code),
    .cmd_bank  (cmd_bank),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .bank_open (bank_open),
    .rd_window (rd_window),
    .wr_window (wr_window),
    .err_valid (err_valid),
    .err_code  (err_code),
    .rd_count  (rd_count),
    .wr_count  (wr_count)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int          tag;
    logic [2:0]  code;
    logic [2:0]  bank;
    logic [14:0] row;
    logic [9:0]  col;
    logic        ev;
    logic [1:0]  ec;
    logic [7:0]  open;
    logic [15:0] rdc;
    logic [15:0] wrc;
  } exp_t;

  exp_t q[$];
  bit   rd_exp[int];
  bit   wr_exp[int];
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0]  m_open = '0;
  logic [1:0]  m_ec = '0;
  logic [15:0] m_rdc = '0;
  logic [15:0] m_wrc = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare against the scoreboard every cycle.
  always @(negedge CLK) begin
    exp_t e;
    if (q.size() > 0 && q[0].tag == cyc) begin
      e = q.pop_front();
      chk("cmd_valid", {31'd0, cmd_valid}, 32'd1);
      chk("cmd_code", {29'd0, cmd_code}, {29'd0, e.code});
      chk("cmd_bank", {29'd0, cmd_bank}, {29'd0, e.bank});
      chk("cmd_row", {17'd0, cmd_row}, {17'd0, e.row});
      chk("cmd_col", {22'd0, cmd_col}, {22'd0, e.col});
      chk("err_valid", {31'd0, err_valid}, {31'd0, e.ev});
      chk("err_code", {30'd0, err_code}, {30'd0, e.ec});
      chk("bank_open", {24'd0, bank_open}, {24'd0, e.open});
      chk("rd_count", {16'd0, rd_count}, {16'd0, e.rdc});
      chk("wr_count", {16'd0, wr_count}, {16'd0, e.wrc});
    end else begin
      chk("idle_valid", {31'd0, cmd_valid}, 32'd0);
      chk("idle_err", {31'd0, err_valid}, 32'd0);
    end
    chk("rd_window", {31'd0, rd_window}, {31'd0, rd_exp.exists(cyc)});
    chk("wr_window", {31'd0, wr_window}, {31'd0, wr_exp.exists(cyc)});
  end

  task automatic drive(input logic [3:0] bus, input logic [2:0] b,
                       input logic [14:0] a, input logic ck);
    {cs_n, ras_n, cas_n, we_n} = bus;
    ba   = b;
    addr = a;
    cke  = ck;
  endtask

  task automatic issue(input logic [3:0] bus, input logic [2:0] b,
                       input logic [14:0] a, input logic ck = 1'b1);
    exp_t e;
    @(negedge CLK);
    drive(bus, b, a, ck);
    if (!ck || bus[3] || bus == B_NOP) return;
    e.tag  = cyc + 1;
    e.code = bus[2:0];
    e.bank = b;
    e.row  = (bus == B_ACT) ? a : '0;
    e.col  = (bus == B_RD || bus == B_WR) ? a[9:0] : '0;
    e.ev   = 1'b0;
    case (bus)
      B_ACT: begin
        if (m_open[b]) begin e.ev = 1'b1; m_ec = 2'd1; end
        m_open[b] = 1'b1;
      end
      B_PRE: begin
        if (a[10]) m_open = '0;
        else       m_open[b] = 1'b0;
      end
      B_RD, B_WR: begin
        if (m_open[b]) begin
          for (int i = 1; i <= 4; i++) begin
            if (bus == B_RD) rd_exp[cyc + CL + i] = 1'b1;
            else             wr_exp[cyc + CWL + i] = 1'b1;
          end
          if (bus == B_RD && m_rdc != 16'hFFFF) m_rdc++;
          if (bus == B_WR && m_wrc != 16'hFFFF) m_wrc++;
          if (a[10]) m_open[b] = 1'b0;
        end else begin
          e.ev = 1'b1;
          m_ec = 2'd2;
        end
      end
      B_REF: if (m_open != 0) begin e.ev = 1'b1; m_ec = 2'd3; end
      default: ;
    endcase
    e.ec   = m_ec;
    e.open = m_open;
    e.rdc  = m_rdc;
    e.wrc  = m_wrc;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      drive(B_NOP, 3'd0, 15'd0, 1'b1);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rd_exp.delete();
    wr_exp.delete();
    m_open = '0;
    m_ec   = '0;
    m_rdc  = '0;
    m_wrc  = '0;
  endtask

  initial begin
    // Reset held with a toggling bus: everything stays 0.
    repeat (6) begin
      @(negedge CLK);
      drive(4'($urandom), 3'($urandom), 15'($urandom), 1'($urandom));
      #1;
      chk("rst_outs", {8'd0, bank_open, 2'd0, err_code, 3'd0, cmd_valid,
                       1'b0, rd_window, wr_window, err_valid, 8'd0},
          32'd0);
      chk("rst_cnt", {rd_count, wr_count}, 32'd0);
    end
    @(negedge CLK);
    drive(B_NOP, 3'd0, 15'd0, 1'b1);
    RSTn = 1'b1;
    idle(2);
    chk("rel_open", {24'd0, bank_open}, 32'd0);
    chk("rel_rdc", {16'd0, rd_count}, 32'd0);

    // ACT then RD two cycles later, then RDs spaced by 4.
    issue(B_ACT, 3'd2, 15'h1234);
    idle(1);
    issue(B_RD, 3'd2, 15'h0008);
    idle(3);
    issue(B_RD, 3'd2, 15'h0010);
    idle(3);
    issue(B_RD, 3'd2, 15'h0018);
    idle(2);
    // WR with auto-precharge closes bank 2.
    issue(B_WR, 3'd2, 15'h0420);
    idle(1);
    chk("auto_pre", {24'd0, bank_open}, 32'd0);
    idle(10);

    // Error cases.
    issue(B_RD, 3'd5, 15'h0030);
    issue(B_ACT, 3'd0, 15'h0001);
    issue(B_ACT, 3'd0, 15'h0002);
    issue(B_REF, 3'd0, 15'h0000);
    issue(B_ACT, 3'd3, 15'h0abc);
    issue(B_ACT, 3'd7, 15'h7fff);
    idle(1);
    chk("open_037", {24'd0, bank_open}, 32'h89);
    issue(B_PRE, 3'd0, 15'h0400);
    idle(1);
    chk("pre_all", {24'd0, bank_open}, 32'd0);

    // Power-down hides an ACT; error code holds.
    issue(B_ACT, 3'd1, 15'h0055, 1'b0);
    idle(1);
    chk("cke_off", {24'd0, bank_open}, 32'd0);
    chk("ec_hold", {30'd0, err_code}, 32'd3);

    issue(B_MRS, 3'd0, 15'h1d70);
    issue(B_ZQC, 3'd0, 15'h0400);
    issue(B_PRE, 3'd6, 15'h0000);
    issue(B_DES, 3'd1, 15'h0000);
    issue(B_WR, 3'd6, 15'h0040);
    idle(12);

    // Drive the RD counter to saturation.
    issue(B_ACT, 3'd4, 15'h0444);
    while (m_rdc != 16'hFFFF) issue(B_RD, 3'd4, 15'h0008);
    issue(B_RD, 3'd4, 15'h0010);
    idle(1);
    chk("rd_sat", {16'd0, rd_count}, 32'h0000ffff);
    idle(2);

    // Reset in the middle of a running read window.
    @(posedge CLK);
    #1;
    chk("pre_kill", {31'd0, rd_window}, 32'd1);
    #1;
    RSTn = 1'b0;
    model_reset();
    #1;
    chk("rst_kill", {31'd0, rd_window}, 32'd0);
    idle(3);
    RSTn = 1'b1;
    idle(2);
    chk("rst_rdc", {16'd0, rd_count}, 32'd0);
    chk("rst_open", {24'd0, bank_open}, 32'd0);
    idle(4);
    chk("sb_empty", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
